// File: rtl/tl_ad_channel_buffer_if.sv
// TileLink-UL A/D handshake bundle shared by the client and manager sides of the buffer.
// 'slave' is the buffer's view; 'master' is the surrounding environment.
interface tl_ad_channel_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int SRC_W  = 4
);
   localparam int AW_T = 9 + SRC_W + ADDR_W + DATA_W/8 + DATA_W;
   localparam int DW_T = 11 + SRC_W + DATA_W;

   logic            ai_valid;
   logic            ai_ready;
   logic [AW_T-1:0] ai_bits;
   logic            ao_valid;
   logic            ao_ready;
   logic [AW_T-1:0] ao_bits;
   logic            di_valid;
   logic            di_ready;
   logic [DW_T-1:0] di_bits;
   logic            do_valid;
   logic            do_ready;
   logic [DW_T-1:0] do_bits;

   modport master (
      output ai_valid, ai_bits, ao_ready, di_valid, di_bits, do_ready,
      input  ai_ready, ao_valid, ao_bits, di_ready, do_valid, do_bits
   );

   modport slave (
      input  ai_valid, ai_bits, ao_ready, di_valid, di_bits, do_ready,
      output ai_ready, ao_valid, ao_bits, di_ready, do_valid, do_bits
   );
endinterface

// File: rtl/tl_ad_channel_buffer.sv
// TileLink-UL A/D channel buffer: A and D FIFOs, outstanding-request limiter,
// and a sticky flag for illegal multi-beat sizes.

// Circular FIFO with wrap-bit pointers; supports non-power-of-two depths.
module tl_ad_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int PIPE  = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_in_ready,
   input  logic         i_deq,
   output logic         o_empty,
   output logic [W-1:0] o_data,
   output logic [4:0]   o_count
);
   localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   logic [W-1:0] r_mem [DEPTH];
   logic [IW:0]  r_wr;
   logic [IW:0]  r_rd;
   logic         w_full;
   logic         w_push;

   function automatic logic [IW:0] bump(input logic [IW:0] p);
      if (p[IW-1:0] == LAST) return {~p[IW], {IW{1'b0}}};
      return p + {{IW{1'b0}}, 1'b1};
   endfunction

   assign w_full     = (r_wr[IW-1:0] == r_rd[IW-1:0]) && (r_wr[IW] != r_rd[IW]);
   assign o_empty    = (r_wr == r_rd);
   // A full FIFO can take a new entry only when the head leaves on the same edge.
   assign o_in_ready = !w_full || ((PIPE != 0) && i_deq);
   assign w_push     = i_valid && o_in_ready;
   assign o_data     = r_mem[r_rd[IW-1:0]];

   always_comb begin
      o_count = 5'd0;
      if (r_wr[IW] == r_rd[IW]) o_count = 5'(r_wr[IW-1:0]) - 5'(r_rd[IW-1:0]);
      else                      o_count = 5'(DEPTH) - 5'(r_rd[IW-1:0]) + 5'(r_wr[IW-1:0]);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= bump(r_wr);
         if (i_deq)  r_rd <= bump(r_rd);
      end
   end

   // NOTE: storage has no reset; occupancy is defined by the pointers alone.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr[IW-1:0]] <= i_data;
   end
endmodule

module tl_ad_channel_buffer #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int SRC_W        = 4,
   parameter int A_DEPTH      = 2,
   parameter int D_DEPTH      = 2,
   parameter int PIPE         = 1,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   tl_ad_channel_buffer_if.slave      bus,
   output logic [4:0]                 a_count,
   output logic [4:0]                 d_count,
   output logic [7:0]                 inflight,
   output logic                       limit_hit,
   output logic                       err_size
);
   localparam int         AW_T     = 9 + SRC_W + ADDR_W + DATA_W/8 + DATA_W;
   localparam int         DW_T     = 11 + SRC_W + DATA_W;
   localparam logic [7:0] MAX_I    = 8'(MAX_INFLIGHT);
   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

   logic       w_a_empty;
   logic       w_d_empty;
   logic       w_ai_fire;
   logic       w_ao_fire;
   logic       w_do_fire;
   logic       w_below;
   logic [7:0] r_inflight;
   logic       r_err_size;

   // ao_valid can only drop through a fire: inflight grows solely on ao_fire.
   assign w_below      = (r_inflight < MAX_I);
   assign bus.ao_valid = !w_a_empty && w_below;
   assign bus.do_valid = !w_d_empty;
   assign w_ai_fire    = bus.ai_valid && bus.ai_ready;
   assign w_ao_fire    = bus.ao_valid && bus.ao_ready;
   assign w_do_fire    = bus.do_valid && bus.do_ready;

   assign inflight  = r_inflight;
   assign limit_hit = (r_inflight == MAX_I);
   assign err_size  = r_err_size;

   tl_ad_fifo #(.W(AW_T), .DEPTH(A_DEPTH), .PIPE(PIPE)) u_a_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_valid    (bus.ai_valid),
      .i_data     (bus.ai_bits),
      .o_in_ready (bus.ai_ready),
      .i_deq      (w_ao_fire),
      .o_empty    (w_a_empty),
      .o_data     (bus.ao_bits),
      .o_count    (a_count)
   );

   tl_ad_fifo #(.W(DW_T), .DEPTH(D_DEPTH), .PIPE(PIPE)) u_d_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_valid    (bus.di_valid),
      .i_data     (bus.di_bits),
      .o_in_ready (bus.di_ready),
      .i_deq      (w_do_fire),
      .o_empty    (w_d_empty),
      .o_data     (bus.do_bits),
      .o_count    (d_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_inflight <= 8'd0;
         r_err_size <= 1'b0;
      end else begin
         if (w_ao_fire && !w_do_fire && (r_inflight != MAX_I))
            r_inflight <= r_inflight + 8'd1;
         else if (w_do_fire && !w_ao_fire && (r_inflight != 8'd0))
            r_inflight <= r_inflight - 8'd1;
         // Oversized requests are flagged but still forwarded untouched.
         if (w_ai_fire && (bus.ai_bits[AW_T-7 -: 3] > MAX_SIZE))
            r_err_size <= 1'b1;
      end
   end
endmodule

// File: tb/tb_tl_ad_channel_buffer.sv
// Directed bench for tl_ad_channel_buffer with a queue scoreboard on both channels
// and a saturating inflight model; a second PIPE=0 instance covers the no-pipe stall.
module tb_tl_ad_channel_buffer;
   localparam int AW  = 9 + 4 + 32 + 8 + 64;
   localparam int DW  = 11 + 4 + 64;
   localparam int MAX = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tl_ad_channel_buffer_if #(.ADDR_W(32), .DATA_W(64), .SRC_W(4)) bus ();
   tl_ad_channel_buffer_if #(.ADDR_W(32), .DATA_W(64), .SRC_W(4)) np ();

   logic [4:0] a_count, d_count, np_a_count, np_d_count;
   logic [7:0] inflight, np_inflight;
   logic       limit_hit, err_size, np_limit_hit, np_err_size;

   tl_ad_channel_buffer #(.A_DEPTH(2), .D_DEPTH(2), .PIPE(1), .MAX_INFLIGHT(MAX)) u_dut (
      .clock(clock), .reset(reset), .bus(bus), .a_count(a_count), .d_count(d_count),
      .inflight(inflight), .limit_hit(limit_hit), .err_size(err_size)
   );

   tl_ad_channel_buffer #(.A_DEPTH(2), .D_DEPTH(2), .PIPE(0), .MAX_INFLIGHT(8)) u_np (
      .clock(clock), .reset(reset), .bus(np), .a_count(np_a_count), .d_count(np_d_count),
      .inflight(np_inflight), .limit_hit(np_limit_hit), .err_size(np_err_size)
   );

   int n_vec = 0;
   int n_mis = 0;
   int ao_fires = 0;
   int do_fires = 0;
   int m_infl = 0;
   logic [AW-1:0] a_exp[$];
   logic [DW-1:0] d_exp[$];
   logic [AW-1:0] mon_a;
   logic [DW-1:0] mon_d;
   logic          mon_ao, mon_do;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] a_pack(input logic [2:0] op, input logic [2:0] sz,
                                            input logic [3:0] src, input logic [31:0] addr,
                                            input logic [63:0] data);
      return {op, 3'd0, sz, src, addr, 8'hFF, data};
   endfunction

   function automatic logic [DW-1:0] d_pack(input logic [2:0] op, input logic [2:0] sz,
                                            input logic [3:0] src, input logic [63:0] data);
      return {op, 2'd0, sz, src, 1'b0, 1'b0, data};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_a(input logic [AW-1:0] b);
      int k = 0;
      bus.ai_valid = 1'b1;
      bus.ai_bits  = b;
      while (!bus.ai_ready && k < 50) begin step(); k++; end
      check("send_a_ready_wait", 128'(bus.ai_ready), 1);
      step();
      bus.ai_valid = 1'b0;
   endtask

   task automatic send_d(input logic [DW-1:0] b);
      int k = 0;
      bus.di_valid = 1'b1;
      bus.di_bits  = b;
      while (!bus.di_ready && k < 50) begin step(); k++; end
      check("send_d_ready_wait", 128'(bus.di_ready), 1);
      step();
      bus.di_valid = 1'b0;
   endtask

   // Scoreboard and inflight model, sampled half a cycle before the edge that fires.
   always @(negedge clock) begin
      if (reset) begin
         a_exp.delete();
         d_exp.delete();
         m_infl = 0;
      end else begin
         mon_ao = bus.ao_valid && bus.ao_ready;
         mon_do = bus.do_valid && bus.do_ready;
         if (mon_ao) begin
            ao_fires++;
            check("a_sb_nonempty", 128'(a_exp.size() != 0), 1);
            if (a_exp.size() != 0) begin
               mon_a = a_exp.pop_front();
               check("ao_bits", 128'(bus.ao_bits), 128'(mon_a));
            end
         end
         if (mon_do) begin
            do_fires++;
            check("d_sb_nonempty", 128'(d_exp.size() != 0), 1);
            if (d_exp.size() != 0) begin
               mon_d = d_exp.pop_front();
               check("do_bits", 128'(bus.do_bits), 128'(mon_d));
            end
         end
         if (bus.ai_valid && bus.ai_ready) a_exp.push_back(bus.ai_bits);
         if (bus.di_valid && bus.di_ready) d_exp.push_back(bus.di_bits);
         if (mon_ao && !mon_do && m_infl < MAX) m_infl++;
         else if (mon_do && !mon_ao && m_infl > 0) m_infl--;
      end
   end

   logic [AW-1:0] g_req, r1, r2, r3, rbig;
   logic [DW-1:0] rsp;
   int k;

   initial begin
      bus.ai_valid = 0; bus.ai_bits = '0; bus.ao_ready = 0;
      bus.di_valid = 0; bus.di_bits = '0; bus.do_ready = 0;
      np.ai_valid  = 0; np.ai_bits  = '0; np.ao_ready  = 0;
      np.di_valid  = 0; np.di_bits  = '0; np.do_ready  = 0;
      g_req = a_pack(3'd4, 3'd3, 4'd2, 32'h8000_0010, 64'h0);
      r1    = a_pack(3'd4, 3'd2, 4'd1, 32'h0000_1000, 64'h0);
      r2    = a_pack(3'd0, 3'd3, 4'd3, 32'h0000_2008, 64'h1111_2222_3333_4444);
      r3    = a_pack(3'd1, 3'd1, 4'd5, 32'h0000_3004, 64'h5555_6666_7777_8888);
      rbig  = a_pack(3'd0, 3'd4, 4'd6, 32'h0000_4000, 64'hA5A5_5A5A_0F0F_F0F0);
      rsp   = d_pack(3'd1, 3'd3, 4'd2, 64'hDEAD_BEEF_CAFE_F00D);

      // Reset state
      repeat (3) step();
      check("rst_ai_ready", 128'(bus.ai_ready), 1);
      check("rst_ao_valid", 128'(bus.ao_valid), 0);
      check("rst_di_ready", 128'(bus.di_ready), 1);
      check("rst_do_valid", 128'(bus.do_valid), 0);
      check("rst_counts", 128'({a_count, d_count, inflight}), 0);
      check("rst_flags", 128'({limit_hit, err_size}), 0);
      reset = 1'b0;
      step();

      // PIPE=0: a full FIFO stays not-ready even while dequeuing
      np.ai_valid = 1'b1;
      np.ai_bits  = r1;
      step();
      np.ai_bits  = r2;
      step();
      np.ai_bits  = r3;
      check("np_full_count", 128'(np_a_count), 2);
      check("np_full_ready", 128'(np.ai_ready), 0);
      np.ao_ready = 1'b1;
      #1;
      check("np_full_ready_deq", 128'(np.ai_ready), 0);
      step();
      check("np_after_deq", 128'(np_a_count), 1);
      np.ai_valid = 1'b0;

      // Single Get: 1-cycle latency, identical bits, inflight counts it
      bus.ai_valid = 1'b1;
      bus.ai_bits  = g_req;
      #1;
      check("no_bypass", 128'(bus.ao_valid), 0);
      step();
      bus.ai_valid = 1'b0;
      check("get_a_count", 128'(a_count), 1);
      check("get_ao_valid", 128'(bus.ao_valid), 1);
      check("get_ao_bits", 128'(bus.ao_bits), 128'(g_req));
      bus.ao_ready = 1'b1;
      step();
      bus.ao_ready = 1'b0;
      check("get_drained", 128'(a_count), 0);
      check("get_inflight", 128'(inflight), 1);
      check("get_ao_low", 128'(bus.ao_valid), 0);

      // Full A FIFO stalls, then PIPE enqueue+dequeue keeps count at 2
      send_a(r1);
      send_a(r2);
      check("full_a_count", 128'(a_count), 2);
      check("full_stall", 128'(bus.ai_ready), 0);
      bus.ai_valid = 1'b1;
      bus.ai_bits  = r3;
      bus.ao_ready = 1'b1;
      #1;
      check("pipe_ready", 128'(bus.ai_ready), 1);
      step();
      bus.ai_valid = 1'b0;
      check("pipe_count", 128'(a_count), 2);
      check("limit_inflight", 128'(inflight), MAX);
      check("limit_hit", 128'(limit_hit), 1);
      check("limit_ao_low", 128'(bus.ao_valid), 0);
      check("limit_stall", 128'(bus.ai_ready), 0);
      step();
      step();
      check("limit_fires", 128'(ao_fires), 2);

      // D path: stalled output stays stable, delivered once, frees one slot
      send_d(rsp);
      check("d_count", 128'(d_count), 1);
      check("d_bits_out", 128'(bus.do_bits), 128'(rsp));
      step();
      check("d_bits_stable", 128'(bus.do_bits), 128'(rsp));
      check("d_valid_held", 128'(bus.do_valid), 1);
      bus.do_ready = 1'b1;
      step();
      bus.do_ready = 1'b0;
      check("d_once", 128'(do_fires), 1);
      check("d_empty", 128'(d_count), 0);
      check("d_inflight_dec", 128'(inflight), 1);
      check("third_a_ready", 128'(bus.ao_valid), 1);
      step();
      check("third_a_fired", 128'(ao_fires), 3);
      check("third_inflight", 128'(inflight), 2);
      check("third_a_count", 128'(a_count), 1);
      check("d_still_once", 128'(do_fires), 1);

      // Oversized request: flag set, entry still forwarded
      check("err_clear", 128'(err_size), 0);
      send_a(rbig);
      check("err_set", 128'(err_size), 1);
      check("err_enq", 128'(a_count), 2);
      bus.do_ready = 1'b1;
      send_d(d_pack(3'd0, 3'd0, 4'd3, 64'h0));
      send_d(d_pack(3'd1, 3'd3, 4'd4, 64'h0123_4567_89AB_CDEF));
      k = 0;
      while ((a_count != 0 || d_count != 0) && k < 30) begin step(); k++; end
      check("drain_a", 128'(a_count), 0);
      check("drain_d", 128'(d_count), 0);
      check("drain_fires", 128'(ao_fires), 5);
      check("err_sticky", 128'(err_size), 1);
      check("drain_inflight", 128'(inflight), 128'(m_infl));
      bus.do_ready = 1'b0;
      bus.ao_ready = 1'b0;

      // Asynchronous reset mid-cycle with traffic queued
      send_a(r1);
      send_a(r2);
      send_d(rsp);
      check("pre_rst_counts", 128'({a_count, d_count}), 128'({5'd2, 5'd1}));
      #2;
      reset = 1'b1;
      #1;
      check("async_counts", 128'({a_count, d_count, inflight}), 0);
      check("async_valids", 128'({bus.ao_valid, bus.do_valid}), 0);
      check("async_flags", 128'({limit_hit, err_size}), 0);
      check("async_ready", 128'({bus.ai_ready, bus.di_ready}), 128'(2'b11));
      step();
      reset = 1'b0;

      // Underflow: response with nothing outstanding leaves inflight at 0
      bus.do_ready = 1'b1;
      send_d(rsp);
      step();
      step();
      check("underflow_inflight", 128'(inflight), 0);
      check("underflow_model", 128'(inflight), 128'(m_infl));
      check("underflow_d_empty", 128'(d_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
